// File: rtl/seaquest_slot_allocator.sv
// Seaquest object-slot allocator: grants free slot indices to the spawn logic over a req/ack handshake.
// Optional feature macro SLOT_ALLOC_FREE_CHK_EN: sticky err_free flag on illegal frees.
module seaquest_slot_allocator #(
  parameter int SLOTS      = 5,
  parameter int IDX_W      = 3,
  parameter int CNT_W      = 4,
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req,
  output logic             alloc_ack,
  output logic             alloc_nack,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             free_en,
  input  logic [IDX_W-1:0] free_idx,
  input  logic             clear_all,
  output logic [SLOTS-1:0] busy_mask,
  output logic [CNT_W-1:0] free_count,
  output logic             full,
  output logic             empty,
  output logic             err_free
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_ACK,
    ST_NACK
  } state_t;

  localparam logic [CNT_W-1:0] SLOTS_CNT = CNT_W'(SLOTS);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] cand_next;
  logic [SLOTS-1:0] free_onehot;
  logic [SLOTS-1:0] grant_onehot;
  logic [SLOTS-1:0] busy_next;
  logic [CNT_W-1:0] count_next;
  logic             free_ok;
  logic             grant;
  logic             nack_fire;

  assign full  = (free_count == '0);
  assign empty = (free_count == SLOTS_CNT);

  // Free-slot priority encoder over ~busy_mask; the last match in loop order wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cand_next = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (!busy_mask[i]) cand_next = IDX_W'(i);
      end
    end else begin
      for (int i = SLOTS - 1; i >= 0; i--) begin
        if (!busy_mask[i]) cand_next = IDX_W'(i);
      end
    end
  end

  assign grant     = (state == ST_ACK) && !clear_all;
  assign nack_fire = (state == ST_NACK) && !clear_all;

  // Out-of-range free indices decode to an all-zero one-hot, so they never touch the mask.
  always_comb begin
    free_onehot  = '0;
    grant_onehot = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (free_en && (int'(free_idx) == i)) free_onehot[i] = 1'b1;
      if (grant && (int'(cand_idx) == i))   grant_onehot[i] = 1'b1;
    end
  end

  assign free_ok = |(free_onehot & busy_mask);

  // The granted slot was free at lookup and nothing else can claim it, so free and grant never collide.
  always_comb begin
    busy_next  = (busy_mask & ~free_onehot) | grant_onehot;
    count_next = free_count + CNT_W'(free_ok) - CNT_W'(grant);
    if (clear_all) begin
      busy_next  = '0;
      count_next = SLOTS_CNT;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (alloc_req) state_next = full ? ST_NACK : ST_LOOKUP;
      end
      ST_LOOKUP: state_next = ST_ACK;
      ST_ACK:    state_next = ST_IDLE;
      ST_NACK:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (clear_all) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cand_idx   <= '0;
      busy_mask  <= '0;
      free_count <= SLOTS_CNT;
      alloc_ack  <= 1'b0;
      alloc_nack <= 1'b0;
      alloc_idx  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of order.
      state      <= state_next;
      busy_mask  <= busy_next;
      free_count <= count_next;
      alloc_ack  <= grant;
      alloc_nack <= nack_fire;
      if (state == ST_LOOKUP) cand_idx <= cand_next;
      if (grant) alloc_idx <= cand_idx;
    end
  end

`ifdef SLOT_ALLOC_FREE_CHK_EN
  // Any free that does not release a busy slot is an error, even when a clear wins the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_free <= 1'b0;
    end else if (free_en && !free_ok) begin
      err_free <= 1'b1;
    end
  end
`else
  assign err_free = 1'b0;
`endif

endmodule

// File: tb/tb_seaquest_slot_allocator.sv
// Self-checking bench for seaquest_slot_allocator: directed scenarios plus randomized ops against a slot-set model.
module tb_seaquest_slot_allocator;

  localparam int SLOTS = 5;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;
`ifdef SLOT_ALLOC_FREE_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             alloc_req = 1'b0;
  logic             alloc_ack;
  logic             alloc_nack;
  logic [IDX_W-1:0] alloc_idx;
  logic             free_en = 1'b0;
  logic [IDX_W-1:0] free_idx = '0;
  logic             clear_all = 1'b0;
  logic [SLOTS-1:0] busy_mask;
  logic [CNT_W-1:0] free_count;
  logic             full;
  logic             empty;
  logic             err_free;

  logic             hf_req = 1'b0;
  logic             hf_ack;
  logic             hf_nack;
  logic [IDX_W-1:0] hf_idx;
  logic             hf_free_en = 1'b0;
  logic [IDX_W-1:0] hf_free_idx = '0;
  logic             hf_clear = 1'b0;
  logic [SLOTS-1:0] hf_mask;
  logic [CNT_W-1:0] hf_count;
  logic             hf_full;
  logic             hf_empty;
  logic             hf_err;

  int n_checks = 0;
  int n_fail = 0;

  bit m_busy [SLOTS];
  bit m_err;

  always #5 clk = ~clk;

  seaquest_slot_allocator #(.SLOTS(SLOTS), .IDX_W(IDX_W), .CNT_W(CNT_W), .HIGH_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_nack(alloc_nack),
    .alloc_idx(alloc_idx), .free_en(free_en), .free_idx(free_idx), .clear_all(clear_all),
    .busy_mask(busy_mask), .free_count(free_count), .full(full), .empty(empty), .err_free(err_free)
  );

  seaquest_slot_allocator #(.SLOTS(SLOTS), .IDX_W(IDX_W), .CNT_W(CNT_W), .HIGH_FIRST(1'b1)) dut_hf (
    .clk(clk), .rst_n(rst_n), .alloc_req(hf_req), .alloc_ack(hf_ack), .alloc_nack(hf_nack),
    .alloc_idx(hf_idx), .free_en(hf_free_en), .free_idx(hf_free_idx), .clear_all(hf_clear),
    .busy_mask(hf_mask), .free_count(hf_count), .full(hf_full), .empty(hf_empty), .err_free(hf_err)
  );

  // ---------------- reference model: a set of occupied slots ----------------
  function automatic logic [SLOTS-1:0] m_mask();
    logic [SLOTS-1:0] m = '0;
    for (int i = 0; i < SLOTS; i++) if (m_busy[i]) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (!m_busy[i]) n++;
    return n;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < SLOTS; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic void m_free(input int idx);
    if (idx < SLOTS && m_busy[idx]) m_busy[idx] = 1'b0;
    else m_err = 1'b1;
  endfunction

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic do_reset();
    rst_n = 1'b0; alloc_req = 1'b0; free_en = 1'b0; clear_all = 1'b0; hf_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < SLOTS; i++) m_busy[i] = 1'b0;
    m_err = 1'b0;
  endtask

  // Raises alloc_req until ack/nack (bounded); optional free pulse reaching edge 2 (phase 1) or edge 3 (phase 2).
  task automatic run_req(input int phase, input logic [IDX_W-1:0] fidx, output int lat,
                         output bit acked, output bit nacked, output logic [IDX_W-1:0] idx);
    lat = 0; acked = 1'b0; nacked = 1'b0; idx = '0;
    alloc_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (alloc_ack || alloc_nack) begin
        acked = alloc_ack; nacked = alloc_nack; lat = c; idx = alloc_idx;
        break;
      end
      free_en  = (c == phase);
      free_idx = fidx;
    end
    alloc_req = 1'b0;
    free_en   = 1'b0;
  endtask

  task automatic pulse_free(input logic [IDX_W-1:0] fidx);
    free_en = 1'b1; free_idx = fidx;
    @(negedge clk);
    free_en = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (busy_mask !== 5'b00000) begin n_fail++; $display("FAIL reset_mask got %b want 00000", busy_mask); end
    n_checks++; if (free_count !== 4'd5) begin n_fail++; $display("FAIL reset_count got %0d want 5", free_count); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); end
    n_checks++; if (alloc_ack !== 1'b0 || alloc_nack !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got ack=%b nack=%b want 0 0", alloc_ack, alloc_nack); end
    n_checks++; if (alloc_idx !== 3'd0 || err_free !== 1'b0) begin n_fail++; $display("FAIL reset_idx_err got idx=%0d err=%b want 0 0", alloc_idx, err_free); end
  endtask

  task automatic test_single_grant();
    int lat; bit a, n; logic [IDX_W-1:0] idx;
    do_reset();
    run_req(0, '0, lat, a, n, idx);
    n_checks++; if (!(a && lat == 3)) begin n_fail++; $display("FAIL t1_latency got ack=%b lat=%0d want ack=1 lat=3", a, lat); end
    n_checks++; if (idx !== 3'd0) begin n_fail++; $display("FAIL t1_idx got %0d want 0", idx); end
    n_checks++; if (busy_mask !== 5'b00001 || free_count !== 4'd4) begin n_fail++; $display("FAIL t1_state got mask=%b cnt=%0d want 00001 4", busy_mask, free_count); end
    @(negedge clk);
    n_checks++; if (alloc_ack !== 1'b0) begin n_fail++; $display("FAIL t1_ack_width got ack=%b want 0", alloc_ack); end
  endtask

  // alloc_req held high: a grant every 3 cycles, then a nack 2 cycles after the request seen while full.
  task automatic test_back_to_back();
    int errs = 0;
    do_reset();
    alloc_req = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      bit exp_ack;
      bit exp_nack;
      @(negedge clk);
      exp_ack  = (c % 3 == 0) && (c <= 15);
      exp_nack = (c == 17);
      if (alloc_ack !== exp_ack || alloc_nack !== exp_nack) errs++;
      if (exp_ack && alloc_idx !== 3'(c / 3 - 1)) errs++;
      if (c == 17) alloc_req = 1'b0;
    end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL t2_sequence got %0d cycle errors want 0", errs); end
    n_checks++; if (busy_mask !== 5'b11111 || full !== 1'b1) begin n_fail++; $display("FAIL t2_full got mask=%b full=%b want 11111 1", busy_mask, full); end
    @(negedge clk);
    n_checks++; if (alloc_nack !== 1'b0 || busy_mask !== 5'b11111) begin n_fail++; $display("FAIL t2_after_nack got nack=%b mask=%b want 0 11111", alloc_nack, busy_mask); end
  endtask

  task automatic test_free_regrant();
    int lat; bit a, n; logic [IDX_W-1:0] idx;
    pulse_free(3'd2);
    n_checks++; if (busy_mask !== 5'b11011 || free_count !== 4'd1) begin n_fail++; $display("FAIL t3_free got mask=%b cnt=%0d want 11011 1", busy_mask, free_count); end
    run_req(0, '0, lat, a, n, idx);
    n_checks++; if (!(a && idx == 3'd2)) begin n_fail++; $display("FAIL t3_regrant got ack=%b idx=%0d want 1 2", a, idx); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL t3_full got %b want 1", full); end
  endtask

  task automatic test_high_first();
    int lat[2]; logic [IDX_W-1:0] got[2];
    do_reset();
    for (int k = 0; k < 2; k++) begin
      lat[k] = 0; got[k] = '0;
      hf_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (hf_ack) begin lat[k] = c; got[k] = hf_idx; break; end
      end
      hf_req = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (lat[0] != 3 || got[0] !== 3'd4) begin n_fail++; $display("FAIL t4_first got lat=%0d idx=%0d want 3 4", lat[0], got[0]); end
    n_checks++; if (lat[1] != 3 || got[1] !== 3'd3) begin n_fail++; $display("FAIL t4_second got lat=%0d idx=%0d want 3 3", lat[1], got[1]); end
    n_checks++; if (hf_mask !== 5'b11000 || hf_count !== 4'd3) begin n_fail++; $display("FAIL t4_mask got %b cnt=%0d want 11000 3", hf_mask, hf_count); end
  endtask

  task automatic test_clear_in_lookup();
    int lat; bit a, n; logic [IDX_W-1:0] idx; int stray = 0;
    do_reset();
    run_req(0, '0, lat, a, n, idx);
    run_req(0, '0, lat, a, n, idx);
    alloc_req = 1'b1;
    @(negedge clk);
    clear_all = 1'b1; alloc_req = 1'b0;
    @(negedge clk);
    clear_all = 1'b0;
    n_checks++; if (busy_mask !== 5'b00000 || empty !== 1'b1 || free_count !== 4'd5) begin n_fail++; $display("FAIL t5_cleared got mask=%b empty=%b cnt=%0d want 00000 1 5", busy_mask, empty, free_count); end
    for (int c = 0; c < 4; c++) begin
      if (alloc_ack || alloc_nack) stray++;
      @(negedge clk);
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL t5_no_pulse got %0d stray pulses want 0", stray); end
    run_req(0, '0, lat, a, n, idx);
    n_checks++; if (!(a && lat == 3 && idx == 3'd0)) begin n_fail++; $display("FAIL t5_next_req got ack=%b lat=%0d idx=%0d want 1 3 0", a, lat, idx); end
  endtask

  task automatic test_free_check();
    do_reset();
    pulse_free(3'd6);
    n_checks++; if (err_free !== CHK_EN || busy_mask !== 5'b00000) begin n_fail++; $display("FAIL t6_oob got err=%b mask=%b want %b 00000", err_free, busy_mask, CHK_EN); end
    do_reset();
    pulse_free(3'd1);
    n_checks++; if (err_free !== CHK_EN || free_count !== 4'd5) begin n_fail++; $display("FAIL t6_idle_free got err=%b cnt=%0d want %b 5", err_free, free_count, CHK_EN); end
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    n_checks++; if (err_free !== CHK_EN) begin n_fail++; $display("FAIL t6_sticky got err=%b want %b", err_free, CHK_EN); end
  endtask

  task automatic test_reset_mid();
    int lat; bit a, n; logic [IDX_W-1:0] idx;
    do_reset();
    run_req(0, '0, lat, a, n, idx);
    run_req(0, '0, lat, a, n, idx);
    alloc_req = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy_mask !== 5'b00000 || free_count !== 4'd5 || alloc_idx !== 3'd0) begin n_fail++; $display("FAIL reset_mid_async got mask=%b cnt=%0d idx=%0d want 00000 5 0", busy_mask, free_count, alloc_idx); end
    alloc_req = 1'b0;
    @(negedge clk);
    n_checks++; if (alloc_ack !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_ack got ack=%b want 0", alloc_ack); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 150; it++) begin
      int op;
      int lat;
      bit a;
      bit n;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] fidx;
      op   = int'($urandom_range(0, 9));
      fidx = IDX_W'($urandom_range(0, 7));
      if (op <= 5) begin
        int phase;
        int exp_idx;
        bit exp_full;
        phase    = int'($urandom_range(0, 2));
        exp_full = (m_count() == 0);
        exp_idx  = m_lowest();
        run_req(phase, fidx, lat, a, n, idx);
        if (phase == 1 || (phase == 2 && !exp_full)) m_free(int'(fidx));
        if (!exp_full) m_busy[exp_idx] = 1'b1;
        if (exp_full) begin
          n_checks++; if (!(n && !a && lat == 2)) begin n_fail++; $display("FAIL rnd_nack it=%0d got ack=%b nack=%b lat=%0d want 0 1 2", it, a, n, lat); end
        end else begin
          n_checks++; if (!(a && !n && lat == 3 && idx == 3'(exp_idx))) begin n_fail++; $display("FAIL rnd_grant it=%0d got ack=%b lat=%0d idx=%0d want 1 3 %0d", it, a, lat, idx, exp_idx); end
        end
      end else if (op <= 8) begin
        pulse_free(fidx);
        m_free(int'(fidx));
      end else begin
        free_en = $urandom_range(0, 1) == 1; free_idx = fidx; clear_all = 1'b1;
        if (free_en && !(int'(fidx) < SLOTS && m_busy[int'(fidx)])) m_err = 1'b1;
        @(negedge clk);
        clear_all = 1'b0; free_en = 1'b0;
        for (int i = 0; i < SLOTS; i++) m_busy[i] = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (busy_mask !== m_mask() || free_count !== 4'(m_count()) || full !== (m_count() == 0) ||
          empty !== (m_count() == SLOTS) || alloc_ack !== 1'b0 || alloc_nack !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_state it=%0d got mask=%b cnt=%0d full=%b empty=%b ack=%b nack=%b want mask=%b cnt=%0d pulses=0",
                 it, busy_mask, free_count, full, empty, alloc_ack, alloc_nack, m_mask(), m_count());
      end
      n_checks++; if (err_free !== (CHK_EN & m_err)) begin n_fail++; $display("FAIL rnd_err it=%0d got %b want %b", it, err_free, CHK_EN & m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_free_regrant();
    test_high_first();
    test_clear_in_lookup();
    test_free_check();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
